// File: rtl/match_controller.sv
// Round/match sequencer for the two Stacker games: reset, countdown, play, pause, hold, match end.
// Define ROUND_TIMEOUT_EN to add a per-round tick limit (ROUND_TICKS) resolved by block height.
module match_controller #(
  parameter int unsigned TICK_DIV        = 100000000,
  parameter int unsigned COUNTDOWN_TICKS = 3,
  parameter int unsigned HOLD_TICKS      = 2,
  parameter int unsigned ROUNDS_TO_WIN   = 2
`ifdef ROUND_TIMEOUT_EN
  ,
  parameter int unsigned ROUND_TICKS     = 30
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_pulse,
  input  logic       pause_pulse,
  input  logic [1:0] state_l,
  input  logic [1:0] state_r,
  input  logic [3:0] height_l,
  input  logic [3:0] height_r,
  output logic       game_rst,
  output logic       game_paused,
  output logic [2:0] phase,
  output logic [3:0] countdown,
  output logic [2:0] score_l,
  output logic [2:0] score_r,
  output logic [1:0] round_winner,
  output logic [1:0] match_winner
);

  localparam int unsigned     TickW     = $clog2(TICK_DIV);
  localparam logic [TickW-1:0] TickLast = TickW'(TICK_DIV - 1);
  localparam logic [3:0]      CountInit = 4'(COUNTDOWN_TICKS);
  localparam logic [3:0]      HoldLast  = 4'(HOLD_TICKS - 1);
  localparam logic [2:0]      WinScore  = 3'(ROUNDS_TO_WIN);

  typedef enum logic [2:0] {
    StIdle       = 3'd0,
    StResetGames = 3'd1,
    StCountdown  = 3'd2,
    StPlay       = 3'd3,
    StPaused     = 3'd4,
    StRoundEnd   = 3'd5,
    StMatchEnd   = 3'd6
  } phase_e;

  phase_e           phase_q;
  logic [TickW-1:0] tick_cnt;
  logic [3:0]       hold_cnt;
  logic             tick;
  logic             l_win, l_lose, r_win, r_lose;
  logic [1:0]       by_height;
  logic [1:0]       result;

`ifdef ROUND_TIMEOUT_EN
  localparam int unsigned      RoundW    = $clog2(ROUND_TICKS + 1);
  localparam logic [RoundW-1:0] RoundLast = RoundW'(ROUND_TICKS - 1);
  logic [RoundW-1:0] round_cnt;
`endif

  assign tick  = (tick_cnt == TickLast);
  assign phase = phase_q;

  // Round result: 0 none, 1 left, 2 right, 3 draw. A win outranks a loss.
  always_comb begin
    l_win     = (state_l == 2'd1);
    l_lose    = (state_l == 2'd2);
    r_win     = (state_r == 2'd1);
    r_lose    = (state_r == 2'd2);
    by_height = (height_l > height_r) ? 2'd1 : (height_r > height_l) ? 2'd2 : 2'd3;
    result    = 2'd0;
    if (l_win && r_win)        result = 2'd3;
    else if (l_win)            result = 2'd1;
    else if (r_win)            result = 2'd2;
    else if (l_lose && r_lose) result = by_height;
    else if (l_lose)           result = 2'd2;
    else if (r_lose)           result = 2'd1;
`ifdef ROUND_TIMEOUT_EN
    else if (tick && round_cnt == RoundLast) result = by_height;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q      <= StIdle;
      game_rst     <= 1'b1;
      game_paused  <= 1'b1;
      countdown    <= '0;
      score_l      <= '0;
      score_r      <= '0;
      round_winner <= '0;
      match_winner <= '0;
      tick_cnt     <= '0;
      hold_cnt     <= '0;
`ifdef ROUND_TIMEOUT_EN
      round_cnt    <= '0;
`endif
    end else begin
      unique case (phase_q)
        StIdle, StMatchEnd: begin
          game_rst <= 1'b0;
          if (start_pulse) begin
            phase_q      <= StResetGames;
            game_rst     <= 1'b1;
            tick_cnt     <= '0;
            score_l      <= '0;
            score_r      <= '0;
            round_winner <= '0;
            match_winner <= '0;
          end
        end
        StResetGames: begin
          // tick_cnt doubles as the two-cycle reset stretch counter
          if (tick_cnt == TickW'(1)) begin
            phase_q   <= StCountdown;
            game_rst  <= 1'b0;
            countdown <= CountInit;
            tick_cnt  <= '0;
          end else begin
            tick_cnt <= tick_cnt + TickW'(1);
          end
        end
        StCountdown: begin
          if (!tick) begin
            tick_cnt <= tick_cnt + TickW'(1);
          end else begin
            tick_cnt  <= '0;
            countdown <= countdown - 4'd1;
            if (countdown == 4'd1) begin
              phase_q     <= StPlay;
              game_paused <= 1'b0;
`ifdef ROUND_TIMEOUT_EN
              round_cnt   <= '0;
`endif
            end
          end
        end
        StPlay: begin
          if (result != 2'd0) begin
            phase_q      <= StRoundEnd;
            game_paused  <= 1'b1;
            tick_cnt     <= '0;
            hold_cnt     <= '0;
            round_winner <= result;
            if (result == 2'd1 && score_l != 3'd7) score_l <= score_l + 3'd1;
            if (result == 2'd2 && score_r != 3'd7) score_r <= score_r + 3'd1;
          end else begin
            tick_cnt <= tick ? '0 : tick_cnt + TickW'(1);
`ifdef ROUND_TIMEOUT_EN
            if (tick) round_cnt <= round_cnt + RoundW'(1);
`endif
            if (pause_pulse) begin
              phase_q     <= StPaused;
              game_paused <= 1'b1;
            end
          end
        end
        StPaused: begin
          if (pause_pulse) begin
            phase_q     <= StPlay;
            game_paused <= 1'b0;
          end
        end
        StRoundEnd: begin
          if (!tick) begin
            tick_cnt <= tick_cnt + TickW'(1);
          end else begin
            tick_cnt <= '0;
            hold_cnt <= hold_cnt + 4'd1;
            if (hold_cnt == HoldLast) begin
              if (score_l >= WinScore) begin
                phase_q      <= StMatchEnd;
                match_winner <= 2'd1;
              end else if (score_r >= WinScore) begin
                phase_q      <= StMatchEnd;
                match_winner <= 2'd2;
              end else begin
                phase_q  <= StResetGames;
                game_rst <= 1'b1;
              end
            end
          end
        end
        default: begin
          phase_q     <= StIdle;
          game_rst    <= 1'b0;
          game_paused <= 1'b1;
          countdown   <= '0;
          tick_cnt    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_match_controller.sv
// Bench for match_controller: phase-age reference model checked every cycle plus directed literals.
module tb_match_controller;

  localparam int TD  = 4;
  localparam int CDT = 3;
  localparam int HT  = 2;
  localparam int RTW = 2;
`ifdef ROUND_TIMEOUT_EN
  localparam int RT  = 5;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_pulse, pause_pulse;
  logic [1:0] state_l, state_r;
  logic [3:0] height_l, height_r;
  logic       game_rst, game_paused;
  logic [2:0] phase;
  logic [3:0] countdown;
  logic [2:0] score_l, score_r;
  logic [1:0] round_winner, match_winner;

  always #5 clk = ~clk;

  match_controller #(
    .TICK_DIV        (TD),
    .COUNTDOWN_TICKS (CDT),
    .HOLD_TICKS      (HT),
    .ROUNDS_TO_WIN   (RTW)
`ifdef ROUND_TIMEOUT_EN
    ,
    .ROUND_TICKS     (RT)
`endif
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_pulse  (start_pulse),
    .pause_pulse  (pause_pulse),
    .state_l      (state_l),
    .state_r      (state_r),
    .height_l     (height_l),
    .height_r     (height_r),
    .game_rst     (game_rst),
    .game_paused  (game_paused),
    .phase        (phase),
    .countdown    (countdown),
    .score_l      (score_l),
    .score_r      (score_r),
    .round_winner (round_winner),
    .match_winner (match_winner)
  );

  int n_cmp = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  // Reference model: phase plus cycles spent in it; durations come straight from the parameters.
  int m_phase = 0, m_age = 0, m_play = 0;
  int m_sl = 0, m_sr = 0, m_rw = 0, m_mw = 0;
  bit m_rstf = 1'b1;
  int m_nxt, m_r;

  function automatic int height_judge(input int hl, input int hr);
    if (hl > hr) return 1;
    if (hr > hl) return 2;
    return 3;
  endfunction

  function automatic int judge(input int sl, input int sr, input int hl, input int hr);
    if (sl == 0 && sr == 0) return 0;
    if (sl == 1 && sr == 1) return 3;
    if (sl == 1) return 1;
    if (sr == 1) return 2;
    if (sl == 2 && sr == 2) return height_judge(hl, hr);
    return (sl == 2) ? 2 : 1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_age = 0; m_play = 0;
      m_sl = 0; m_sr = 0; m_rw = 0; m_mw = 0;
      m_rstf = 1'b1;
    end else begin
      m_nxt  = m_phase;
      m_rstf = 1'b0;
      case (m_phase)
        0, 6: if (start_pulse) begin
          m_nxt = 1; m_sl = 0; m_sr = 0; m_rw = 0; m_mw = 0;
        end
        1: if (m_age == 1) m_nxt = 2;
        2: if (m_age == CDT * TD - 1) begin m_nxt = 3; m_play = 0; end
        3: begin
          m_r = judge(int'(state_l), int'(state_r), int'(height_l), int'(height_r));
`ifdef ROUND_TIMEOUT_EN
          if (m_r == 0 && m_play == RT * TD - 1) m_r = height_judge(int'(height_l), int'(height_r));
`endif
          m_play++;
          if (m_r != 0) begin
            m_rw = m_r;
            if (m_r == 1 && m_sl < 7) m_sl++;
            if (m_r == 2 && m_sr < 7) m_sr++;
            m_nxt = 5;
          end else if (pause_pulse) begin
            m_nxt = 4;
          end
        end
        4: if (pause_pulse) m_nxt = 3;
        5: if (m_age == HT * TD - 1) begin
          if (m_sl >= RTW)      begin m_nxt = 6; m_mw = 1; end
          else if (m_sr >= RTW) begin m_nxt = 6; m_mw = 2; end
          else m_nxt = 1;
        end
        default: m_nxt = 0;
      endcase
      if (m_nxt != m_phase) m_age = 0;
      else m_age++;
      m_phase = m_nxt;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model.phase", int'(phase), m_phase);
      chk("model.countdown", int'(countdown), (m_phase == 2) ? CDT - m_age / TD : 0);
      chk("model.game_rst", int'(game_rst), (m_phase == 1 || m_rstf) ? 1 : 0);
      chk("model.game_paused", int'(game_paused), (m_phase == 3) ? 0 : 1);
      chk("model.score_l", int'(score_l), m_sl);
      chk("model.score_r", int'(score_r), m_sr);
      chk("model.round_winner", int'(round_winner), m_rw);
      chk("model.match_winner", int'(match_winner), m_mw);
    end
  end

  task automatic wait_phase(input int p, input int budget, input string nm);
    int n = 0;
    while (int'(phase) != p && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(nm, int'(phase), p);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; start_pulse = 1'b0; pause_pulse = 1'b0;
    state_l = 2'd0; state_r = 2'd0; height_l = 4'd0; height_r = 4'd0;
    repeat (3) @(negedge clk);
    cmp_en = 1'b1;
    chk("reset.phase", int'(phase), 0);
    chk("reset.game_rst", int'(game_rst), 1);
    chk("reset.game_paused", int'(game_paused), 1);
    chk("reset.countdown", int'(countdown), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle.game_rst", int'(game_rst), 0);

    // 1: start at edge k; cycle indices below are relative to k
    start_pulse = 1'b1; @(negedge clk); start_pulse = 1'b0;     // k+1
    chk("t1.rst_k1", int'(game_rst), 1);
    @(negedge clk);                                             // k+2
    chk("t1.rst_k2", int'(game_rst), 1);
    @(negedge clk);                                             // k+3
    chk("t1.cd3", int'(countdown), 3);
    chk("t1.rst_off", int'(game_rst), 0);
    repeat (4) @(negedge clk);                                  // k+7
    chk("t1.cd2", int'(countdown), 2);
    pause_pulse = 1'b1; @(negedge clk); pause_pulse = 1'b0;     // k+8, pause ignored
    repeat (3) @(negedge clk);                                  // k+11
    chk("t1.cd1", int'(countdown), 1);
    start_pulse = 1'b1; @(negedge clk); start_pulse = 1'b0;     // k+12, start ignored
    repeat (2) @(negedge clk);                                  // k+14
    chk("t1.still_cd", int'(phase), 2);
    @(negedge clk);                                             // k+15
    chk("t1.play", int'(phase), 3);
    chk("t1.unpaused", int'(game_paused), 0);

    // 2: left wins; 8-cycle hold then 2-cycle game reset
    state_l = 2'd1; @(negedge clk); state_l = 2'd0;             // k+16
    chk("t2.score_l", int'(score_l), 1);
    chk("t2.rw", int'(round_winner), 1);
    chk("t2.phase", int'(phase), 5);
    repeat (7) @(negedge clk);                                  // k+23
    chk("t2.hold", int'(phase), 5);
    @(negedge clk);                                             // k+24
    chk("t2.rg", int'(phase), 1);
    chk("t2.rst1", int'(game_rst), 1);
    @(negedge clk);
    chk("t2.rst2", int'(game_rst), 1);
    @(negedge clk);
    chk("t2.cd", int'(phase), 2);

    // 3a: both lose, equal heights -> draw and replay
    wait_phase(3, 40, "t3.wait_play");
    state_l = 2'd2; state_r = 2'd2; height_l = 4'd6; height_r = 4'd6;
    @(negedge clk); state_l = 2'd0; state_r = 2'd0;
    chk("t3.draw", int'(round_winner), 3);
    chk("t3.sl", int'(score_l), 1);
    chk("t3.sr", int'(score_r), 0);
    wait_phase(1, 20, "t3.replay");

    // 4: pause freezes resolution; right scores after resume
    wait_phase(3, 40, "t4.wait_play");
    pause_pulse = 1'b1; @(negedge clk); pause_pulse = 1'b0;
    chk("t4.paused", int'(phase), 4);
    chk("t4.gp", int'(game_paused), 1);
    state_r = 2'd1;
    repeat (3) @(negedge clk);
    chk("t4.no_score", int'(score_r), 0);
    pause_pulse = 1'b1; @(negedge clk); pause_pulse = 1'b0;
    chk("t4.resumed", int'(phase), 3);
    @(negedge clk); state_r = 2'd0;
    chk("t4.score_r", int'(score_r), 1);
    chk("t4.rw", int'(round_winner), 2);

    // 3b/5: both lose 5 vs 3 -> left scores, reaches 2, match ends
    wait_phase(3, 60, "t5.wait_play");
    state_l = 2'd2; state_r = 2'd2; height_l = 4'd5; height_r = 4'd3;
    @(negedge clk); state_l = 2'd0; state_r = 2'd0;
    chk("t5.score_l", int'(score_l), 2);
    repeat (7) @(negedge clk);
    chk("t5.hold", int'(phase), 5);
    @(negedge clk);
    chk("t5.match_end", int'(phase), 6);
    chk("t5.mw", int'(match_winner), 1);
    pause_pulse = 1'b1; @(negedge clk); pause_pulse = 1'b0;
    repeat (2) @(negedge clk);
    start_pulse = 1'b1; @(negedge clk); start_pulse = 1'b0;
    chk("t5.restart", int'(phase), 1);
    chk("t5.cleared_l", int'(score_l), 0);
    chk("t5.cleared_mw", int'(match_winner), 0);

    // lose vs win on the same cycle: the winner scores; start ignored in PLAY
    wait_phase(3, 40, "t5b.wait_play");
    state_l = 2'd2; state_r = 2'd1; start_pulse = 1'b1;
    @(negedge clk); state_l = 2'd0; state_r = 2'd0; start_pulse = 1'b0;
    chk("t5b.score_r", int'(score_r), 1);
    chk("t5b.score_l", int'(score_l), 0);

    // 6: asynchronous reset mid-countdown
    wait_phase(2, 40, "t6.wait_cd");
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6.phase", int'(phase), 0);
    chk("t6.countdown", int'(countdown), 0);
    chk("t6.game_rst", int'(game_rst), 1);
    chk("t6.score_r", int'(score_r), 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

`ifdef ROUND_TIMEOUT_EN
    height_l = 4'd4; height_r = 4'd2;
    start_pulse = 1'b1; @(negedge clk); start_pulse = 1'b0;
    wait_phase(3, 40, "t7.wait_play");
    repeat (19) @(negedge clk);
    chk("t7.before_timeout", int'(phase), 3);
    @(negedge clk);
    chk("t7.timeout_phase", int'(phase), 5);
    chk("t7.timeout_score", int'(score_l), 1);
    chk("t7.timeout_rw", int'(round_winner), 1);
`endif

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
